// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic package: default operand widths and the divider FSM encoding.
// The width constants match the Booth multiplier and adder datapath.
package seq_signed_divider_pkg;

  localparam int DIV_DW = 6;
  localparam int DIV_VW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done bundle between a requester (master) and the divider (slave).
interface seq_signed_divider_if
  import seq_signed_divider_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
);

  // Handshake: start is sampled only while the divider is idle; operands are captured on
  // that edge. busy stays high until the edge that raises done; done is a one-cycle pulse
  // and quotient/remainder/div_zero/overflow are valid from it until the next result.
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/seq_signed_divider_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, compare, subtract.
module div_restore_step #(
  parameter int VW = 3
) (
  input  logic [VW-1:0] part,
  input  logic          bit_in,
  input  logic [VW-1:0] dsr,
  output logic [VW-1:0] part_next,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] diff;

  // The shifted value needs VW+1 bits; after the conditional subtract it is < dsr again.
  assign shifted   = {part, bit_in};
  assign diff      = shifted - {1'b0, dsr};
  assign q_bit     = (shifted >= {1'b0, dsr});
  assign part_next = q_bit ? diff[VW-1:0] : shifted[VW-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, signs fixed up at the end.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_signed_divider_if.slave   bus,
  output div_state_e            state_dbg
);

  localparam int CW = $clog2(DW);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_mag;
  logic [DW-1:0] q_mag;
  logic [VW-1:0] dsr_mag;
  logic [VW-1:0] part;
  logic [VW-1:0] part_nxt;
  logic          q_bit;
  logic          neg_dvd;
  logic          neg_q;
  logic          dz;
  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dsr_abs;

  logic          busy_r;
  logic          done_r;
  logic [DW-1:0] quot_r;
  logic [VW-1:0] rem_r;
  logic          dz_r;
  logic          ov_r;

  // Magnitudes are unsigned, so |-2^(N-1)| = 2^(N-1) still fits in N bits.
  assign dvd_abs = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
  assign dsr_abs = bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;

  div_restore_step #(.VW(VW)) u_step (
    .part      (part),
    .bit_in    (dvd_mag[DW-1]),
    .dsr       (dsr_mag),
    .part_next (part_nxt),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dvd_mag <= '0;
      q_mag   <= '0;
      dsr_mag <= '0;
      part    <= '0;
      neg_dvd <= 1'b0;
      neg_q   <= 1'b0;
      dz      <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dz_r    <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dvd_mag <= dvd_abs;
            dsr_mag <= dsr_abs;
            neg_dvd <= bus.dividend[DW-1];
            neg_q   <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            dz      <= (bus.divisor == '0);
            q_mag   <= '0;
            part    <= '0;
            cnt     <= CW'(DW - 1);
            busy_r  <= 1'b1;
            state   <= (bus.divisor == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          part    <= part_nxt;
          q_mag   <= {q_mag[DW-2:0], q_bit};
          dvd_mag <= {dvd_mag[DW-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          if (dz) begin
            quot_r <= '1;
            rem_r  <= '0;
            dz_r   <= 1'b1;
            ov_r   <= 1'b0;
          end else begin
            quot_r <= neg_q ? -q_mag : q_mag;
            rem_r  <= neg_dvd ? -part : part;
            dz_r   <= 1'b0;
            // A positive quotient with its top bit set can only be -2^(DW-1) / -1.
            ov_r   <= ~neg_q & q_mag[DW-1];
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;
  assign bus.overflow  = ov_r;
  assign state_dbg     = state;

endmodule
